// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with one-hot grant, hold-time watchdog and one dead cycle
// between owners. All outputs are registered.
module rr_req_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 16,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int CNT_W   = $clog2(HOLD_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [ID_W:0]    N_REQ_W   = (ID_W + 1)'(N_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state, state_n;
    logic [ID_W-1:0]  ptr, ptr_n;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic [ID_W-1:0]  gnt_id_n;
    logic             timeout_n;

    logic             arb_found;
    logic [ID_W-1:0]  arb_winner;
    logic [ID_W:0]    arb_idx;
    logic             leave_grant;
    logic             owner_release;

    // Rotating search: first set request at ptr, ptr+1, ... wrapping at N_REQ.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            arb_idx = {1'b0, ptr} + (ID_W + 1)'(i);
            if (arb_idx >= N_REQ_W) begin
                arb_idx = arb_idx - N_REQ_W;
            end
            if (!arb_found && req[arb_idx[ID_W-1:0]]) begin
                arb_found  = 1'b1;
                arb_winner = arb_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        hold_cnt_n    = hold_cnt;
        gnt_n         = gnt;
        gnt_id_n      = gnt_id;
        timeout_n     = 1'b0;
        leave_grant   = 1'b0;
        owner_release = done[gnt_id] || !req[gnt_id];

        case (state)
            IDLE, GAP: begin
                gnt_n      = '0;
                gnt_id_n   = '0;
                hold_cnt_n = '0;
                state_n    = IDLE;
                if (arb_found) begin
                    state_n           = GRANT;
                    gnt_n[arb_winner] = 1'b1;
                    gnt_id_n          = arb_winner;
                end
            end
            GRANT: begin
                // An owner release in the expiry cycle takes precedence, so no timeout pulse.
                if (owner_release) begin
                    leave_grant = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    leave_grant = 1'b1;
                    timeout_n   = 1'b1;
                end else begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
                if (leave_grant) begin
                    state_n    = GAP;
                    gnt_n      = '0;
                    gnt_id_n   = '0;
                    hold_cnt_n = '0;
                    ptr_n      = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
                end
            end
            default: begin
                state_n    = IDLE;
                gnt_n      = '0;
                gnt_id_n   = '0;
                hold_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_cnt_n;
            gnt       <= gnt_n;
            gnt_valid <= |gnt_n;
            gnt_id    <= gnt_id_n;
            timeout   <= timeout_n;
            busy      <= (state_n != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        assert ($onehot0(gnt));
    end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: directed scenarios, an owner/pointer model checked
// every cycle, and literal expectations at the key points of each scenario.
module tb_rr_req_arbiter;

    localparam int N_REQ    = 4;
    localparam int HOLD_MAX = 16;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    rr_req_arbiter #(.N_REQ(N_REQ), .HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the resource, how long they have held it, whose turn is next.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_gap   = 1'b0;
    bit m_to    = 1'b0;
    int k;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_gap   = 1'b0;
            m_to    = 1'b0;
        end else if (m_owner >= 0) begin
            m_held = m_held + 1;
            m_to   = 1'b0;
            if (done[m_owner[1:0]] || !req[m_owner[1:0]]) begin
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_held == HOLD_MAX) begin
                m_to    = 1'b1;
                m_ptr   = (m_owner + 1) % N_REQ;
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else begin
            m_to  = 1'b0;
            m_gap = 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                k = (m_ptr + i) % N_REQ;
                if (m_owner < 0 && req[k[1:0]]) begin
                    m_owner = k;
                    m_held  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int exp_gnt;
        exp_gnt = (m_owner >= 0) ? (1 << m_owner) : 0;
        check("model_gnt",       int'(gnt),       exp_gnt);
        check("model_gnt_id",    int'(gnt_id),    (m_owner >= 0) ? m_owner : 0);
        check("model_gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
        check("model_timeout",   int'(timeout),   int'(m_to));
        check("model_busy",      int'(busy),      (m_owner >= 0 || m_gap) ? 1 : 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        done = 4'b0000;

        // Reset held two cycles with all requests pending.
        cyc(1);
        check("t1_rst_gnt",  int'(gnt),    0);
        check("t1_rst_id",   int'(gnt_id), 0);
        check("t1_rst_busy", int'(busy),   0);
        cyc(1);
        check("t1_rst2_gnt", int'(gnt),  0);
        check("t1_rst2_busy", int'(busy), 0);
        rst = 1'b0;
        cyc(1);
        check("t1_first_gnt", int'(gnt), 4'b0001);

        // Round robin with done three cycles into each grant: 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            check("t2_order_gnt", int'(gnt), 1 << (i % 4));
            check("t2_order_id",  int'(gnt_id), i % 4);
            cyc(2);
            done = 4'b0001 << (i % 4);
            cyc(1);
            done = 4'b0000;
            check("t2_gap_gnt",  int'(gnt),  0);
            check("t2_gap_busy", int'(busy), 1);
            if (i == 4) req = 4'b0100;
            cyc(1);
        end

        // Lone requester 2 held past the watchdog.
        for (int j = 0; j < 16; j++) begin
            check("t3_hold_gnt", int'(gnt),     4'b0100);
            check("t3_hold_to",  int'(timeout), 0);
            cyc(1);
        end
        check("t3_expire_gnt", int'(gnt),     0);
        check("t3_expire_to",  int'(timeout), 1);
        cyc(1);
        check("t3_regrant_gnt", int'(gnt),     4'b0100);
        check("t3_regrant_to",  int'(timeout), 0);

        // Owner 1: non-owner done ignored, own done at the last hold cycle.
        req = 4'b0010;
        cyc(1);
        check("t4_gap_gnt", int'(gnt), 0);
        cyc(1);
        check("t4_grant_gnt", int'(gnt), 4'b0010);
        done = 4'b1000;
        cyc(1);
        check("t4_ignore_gnt", int'(gnt), 4'b0010);
        done = 4'b0000;
        cyc(14);
        check("t4_last_gnt", int'(gnt), 4'b0010);
        done = 4'b0010;
        cyc(1);
        done = 4'b0000;
        check("t4_release_gnt", int'(gnt),     0);
        check("t4_release_to",  int'(timeout), 0);

        // Owner 2 drops its request; next arbitration starts from 3.
        req = 4'b0100;
        cyc(1);
        check("t5_grant_gnt", int'(gnt), 4'b0100);
        req = 4'b0011;
        cyc(1);
        check("t5_gap_gnt", int'(gnt), 0);
        cyc(1);
        check("t5_next_gnt", int'(gnt), 4'b0001);

        // Reset while owner 3 holds the grant.
        req = 4'b1000;
        cyc(1);
        check("t6_gap_gnt", int'(gnt), 0);
        cyc(1);
        check("t6_grant_gnt", int'(gnt), 4'b1000);
        rst = 1'b1;
        req = 4'b1111;
        cyc(1);
        check("t6_rst_gnt",  int'(gnt),  0);
        check("t6_rst_busy", int'(busy), 0);
        rst = 1'b0;
        cyc(1);
        check("t6_after_gnt", int'(gnt), 4'b0001);
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
